cc_tracker: RTL and testbench
=============================

CC_TRACKER -- requirements
Module: cc_tracker

Interface
REQ-001 Parameter MAX_PENDING, default 4: the maximum number of in-flight CC-setting instructions.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port issue_setcc, input, 1 bit: decode is issuing an instruction that will write CC.
REQ-005 Port issue_ready, output, 1 bit: the tracker can accept issue_setcc this cycle.
REQ-006 Port wb_setcc, input, 1 bit: writeback is retiring a CC-setting instruction this cycle.
REQ-007 Port wb_result, input, 16 bits: the value written back; CC source when wb_setcc=1.
REQ-008 Port flush, input, 1 bit: squash all in-flight (not yet retired) CC writers.
REQ-009 Port nzp, output, 3 bits (lc3b_nzp, [2]=N [1]=Z [0]=P): the architectural CC, driven to the branch comparator.
REQ-010 Port cc_valid, output, 1 bit: nzp reflects every issued CC writer; a branch may resolve.
REQ-011 Port pending, output, clog2(MAX_PENDING+1) bits: the current in-flight writer count.
REQ-012 Port err, output, 1 bit: sticky underflow/overflow error flag.

Function
REQ-013 The CC generation SHALL encode wb_result: N=wb_result[15]; Z=(wb_result==0); P=otherwise; the encoding is always one-hot.
REQ-014 The nzp register SHALL load the generated code on the clock edge where wb_setcc=1, independent of flush and of pending.
REQ-015 Counter update:
- issue_setcc&issue_ready only: pending+1.
- wb_setcc only: pending-1.
- both: pending unchanged.
- neither: pending holds.
REQ-016 issue_ready SHALL be 0 when pending==MAX_PENDING and wb_setcc=0; otherwise 1 (a same-cycle retire frees a slot).
REQ-017 An issue_setcc while issue_ready=0 SHALL be ignored and SHALL set err.
REQ-018 A wb_setcc while pending==0 SHALL still update nzp, SHALL hold pending at 0 (no wrap), and SHALL set err.
REQ-019 With flush=1, the next pending value SHALL be 0 regardless of issue_setcc and wb_setcc; the nzp update under REQ-014 still occurs.
REQ-020 cc_valid SHALL be 1 whenever pending==0 (registered path), subject to REQ-026.
REQ-021 Once set, err SHALL remain 1 until rst.
REQ-022 The block SHALL have no other state machine: its state is the nzp register, the pending counter and err.

Reset
REQ-023 On rst=1, the block SHALL asynchronously set nzp=3'b010, pending=0 and err=0.
REQ-024 While rst=1, cc_valid SHALL be 1 and issue_ready SHALL be 1.
REQ-025 Asserting rst mid-operation SHALL discard all in-flight tracking with no residual effect after deassertion.

Configuration
REQ-026 Macro CC_TRACKER_FWD_EN controls same-cycle CC forwarding.
- Defined: when wb_setcc=1, pending==1 and issue_setcc=0, nzp SHALL output the generated code combinationally and cc_valid SHALL be 1 in that same cycle.
- Undefined: nzp and cc_valid are purely registered, so cc_valid rises the cycle after the last retire.
REQ-027 Forwarding SHALL NOT change the register or counter next-state behaviour.

Verification
REQ-028 Scenario: reset, then idle -> nzp=3'b010, pending=0, cc_valid=1, err=0.
REQ-029 Scenario: issue one writer, then wb_setcc with wb_result=16'h8000 two cycles later -> pending 1 then 0; nzp=3'b100.
- With FWD_EN: cc_valid=1 in the retire cycle.
- Without FWD_EN: cc_valid=1 one cycle later.
REQ-030 Scenario: issue 4 writers back-to-back with MAX_PENDING=4 -> issue_ready=0 at pending=4; a 5th issue is ignored and sets err=1; a simultaneous issue+retire at pending=4 is accepted with pending staying at 4.
REQ-031 Scenario: pending=3, flush and wb_setcc together with wb_result=16'h0000 -> pending=0, nzp=3'b010, err unchanged.
REQ-032 Scenario: wb_setcc with wb_result=16'h0005 at pending=0 -> nzp=3'b001, pending=0, err=1 and stays 1 until rst.
REQ-033 Scenario: rst asserted asynchronously with pending=2 and err=1 -> all outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/cc_tracker.sv
// cc_tracker
// Condition-code scoreboard for an in-order pipeline. It holds the
// architectural NZP register and counts the CC-setting instructions that
// have issued but not yet retired. A branch may resolve only once no CC
// writers remain in flight (cc_valid).
//
// Optional feature: define CC_TRACKER_FWD_EN to forward the CC generated at
// writeback straight to nzp/cc_valid in the cycle the last writer retires.
module cc_tracker #(
    parameter int MAX_PENDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               issue_setcc,
    output logic                               issue_ready,
    input  logic                               wb_setcc,
    input  logic [15:0]                        wb_result,
    input  logic                               flush,
    output logic [2:0]                         nzp,
    output logic                               cc_valid,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               err
);

    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] MaxCount = PW'(MAX_PENDING);
    localparam logic [PW-1:0] OneCount = PW'(1);
    localparam logic [2:0]    NzpReset = 3'b010;

    logic [2:0]    nzp_q;
    logic [2:0]    nzp_d;
    logic [PW-1:0] pending_q;
    logic [PW-1:0] pending_d;
    logic          err_q;
    logic          err_d;

    logic [2:0]    ccGen;
    logic          slotFree;
    logic          issueAccept;
    logic          issueReject;
    logic          underflow;

    // Encode the writeback value as a one-hot N/Z/P condition code.
    always_comb begin
        ccGen = 3'b001;
        if (wb_result[15]) begin
            ccGen = 3'b100;
        end else if (wb_result == 16'h0000) begin
            ccGen = 3'b010;
        end
    end

    // A full tracker still accepts an issue when a retire frees a slot this cycle.
    assign slotFree    = !((pending_q == MaxCount) && !wb_setcc);
    assign issueAccept = issue_setcc && slotFree;
    assign issueReject = issue_setcc && !slotFree;
    assign underflow   = wb_setcc && (pending_q == '0);

    // Next-state for the in-flight counter; flush squashes everything, underflow saturates at zero.
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else if (issueAccept && !wb_setcc) begin
            pending_d = pending_q + OneCount;
        end else if (!issueAccept && wb_setcc && !underflow) begin
            pending_d = pending_q - OneCount;
        end
    end

    // Next-state for the CC register and the sticky error flag.
    always_comb begin
        nzp_d = nzp_q;
        if (wb_setcc) begin
            nzp_d = ccGen;
        end
        err_d = err_q || issueReject || underflow;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzp_q     <= NzpReset;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            nzp_q     <= nzp_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

`ifdef CC_TRACKER_FWD_EN
    logic fwdHit;

    // Bypass the register when the final outstanding writer retires this cycle.
    always_comb begin
        fwdHit   = wb_setcc && (pending_q == OneCount) && !issue_setcc;
        nzp      = fwdHit ? ccGen : nzp_q;
        cc_valid = rst || (pending_q == '0) || fwdHit;
    end
`else
    // Purely registered view: cc_valid rises the cycle after the last retire.
    always_comb begin
        nzp      = nzp_q;
        cc_valid = rst || (pending_q == '0);
    end
`endif

    assign issue_ready = rst || slotFree;
    assign pending     = pending_q;
    assign err         = err_q;

endmodule

// File: tb/tb_cc_tracker.sv
// tb_cc_tracker
// Directed test of cc_tracker with MAX_PENDING=4. Expectations for the
// forwarding cycle follow CC_TRACKER_FWD_EN when it is defined.
module tb_cc_tracker;

    logic        clk;
    logic        rst;
    logic        issue_setcc;
    logic        issue_ready;
    logic        wb_setcc;
    logic [15:0] wb_result;
    logic        flush;
    logic [2:0]  nzp;
    logic        cc_valid;
    logic [2:0]  pending;
    logic        err;

    int checkCount;
    int errorCount;

    cc_tracker #(.MAX_PENDING(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_setcc (issue_setcc),
        .issue_ready (issue_ready),
        .wb_setcc    (wb_setcc),
        .wb_result   (wb_result),
        .flush       (flush),
        .nzp         (nzp),
        .cc_valid    (cc_valid),
        .pending     (pending),
        .err         (err)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and report mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle worth of inputs.
    task automatic applyStimulus(input logic iss, input logic wb, input logic [15:0] res, input logic fl);
        issue_setcc = iss;
        wb_setcc    = wb;
        wb_result   = res;
        flush       = fl;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, let them take effect across one edge, then go idle.
    task automatic runCycle(input logic iss, input logic wb, input logic [15:0] res, input logic fl);
        applyStimulus(iss, wb, res, fl);
        stepClock();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);

        // Reset values while rst is held.
        #3;
        checkOutput("rst_nzp",      16'(nzp),         16'h0002);
        checkOutput("rst_pending",  16'(pending),     16'h0000);
        checkOutput("rst_ccvalid",  16'(cc_valid),    16'h0001);
        checkOutput("rst_err",      16'(err),         16'h0000);
        checkOutput("rst_ready",    16'(issue_ready), 16'h0001);
        stepClock();
        rst = 1'b0;
        stepClock();
        checkOutput("idle_nzp",     16'(nzp),         16'h0002);
        checkOutput("idle_ccvalid", 16'(cc_valid),    16'h0001);

        // One writer issues, retires two cycles later with a negative result.
        runCycle(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("one_pending1", 16'(pending),     16'h0001);
        checkOutput("one_ccvalid0", 16'(cc_valid),    16'h0000);
        stepClock();
        checkOutput("one_hold",     16'(pending),     16'h0001);
        applyStimulus(1'b0, 1'b1, 16'h8000, 1'b0);
        #1;
`ifdef CC_TRACKER_FWD_EN
        checkOutput("fwd_ccvalid",  16'(cc_valid),    16'h0001);
        checkOutput("fwd_nzp",      16'(nzp),         16'h0004);
`else
        checkOutput("nofwd_ccvalid", 16'(cc_valid),   16'h0000);
        checkOutput("nofwd_nzp",    16'(nzp),         16'h0002);
`endif
        stepClock();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("one_pending0", 16'(pending),     16'h0000);
        checkOutput("one_nzp_n",    16'(nzp),         16'h0004);
        checkOutput("one_ccvalid1", 16'(cc_valid),    16'h0001);
        checkOutput("one_err",      16'(err),         16'h0000);

        // Fill to MAX_PENDING, then overflow and a simultaneous issue+retire.
        for (int i = 1; i <= 4; i++) begin
            runCycle(1'b1, 1'b0, 16'h0000, 1'b0);
            checkOutput($sformatf("fill_pending%0d", i), 16'(pending), 16'(i));
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        #1;
        checkOutput("full_ready",   16'(issue_ready), 16'h0000);
        stepClock();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("ovf_pending",  16'(pending),     16'h0004);
        checkOutput("ovf_err",      16'(err),         16'h0001);
        applyStimulus(1'b1, 1'b1, 16'h0001, 1'b0);
        #1;
        checkOutput("both_ready",   16'(issue_ready), 16'h0001);
        stepClock();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("both_pending", 16'(pending),     16'h0004);
        checkOutput("both_nzp_p",   16'(nzp),         16'h0001);
        checkOutput("both_ccvalid", 16'(cc_valid),    16'h0000);
        runCycle(1'b0, 1'b1, 16'h8000, 1'b0);
        runCycle(1'b0, 1'b1, 16'h8000, 1'b0);
        checkOutput("drain_pending2", 16'(pending),   16'h0002);
        checkOutput("drain_err",    16'(err),         16'h0001);

        // Asynchronous reset mid-cycle with pending=2 and err=1.
        rst = 1'b1;
        #1;
        checkOutput("arst_nzp",     16'(nzp),         16'h0002);
        checkOutput("arst_pending", 16'(pending),     16'h0000);
        checkOutput("arst_err",     16'(err),         16'h0000);
        checkOutput("arst_ccvalid", 16'(cc_valid),    16'h0001);
        checkOutput("arst_ready",   16'(issue_ready), 16'h0001);
        stepClock();
        rst = 1'b0;
        stepClock();
        checkOutput("post_arst_pending", 16'(pending), 16'h0000);

        // Flush together with a zero-result retire at pending=3.
        for (int i = 0; i < 4; i++) begin
            runCycle(1'b1, 1'b0, 16'h0000, 1'b0);
        end
        runCycle(1'b0, 1'b1, 16'h8000, 1'b0);
        checkOutput("pre_flush_pending", 16'(pending), 16'h0003);
        checkOutput("pre_flush_nzp", 16'(nzp),        16'h0004);
        runCycle(1'b0, 1'b1, 16'h0000, 1'b1);
        checkOutput("flush_pending", 16'(pending),    16'h0000);
        checkOutput("flush_nzp_z",  16'(nzp),         16'h0002);
        checkOutput("flush_err",    16'(err),         16'h0000);

        // Flush wins over a concurrent issue.
        runCycle(1'b1, 1'b0, 16'h0000, 1'b0);
        runCycle(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("pre_flush2",   16'(pending),     16'h0002);
        runCycle(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("flush_issue_pending", 16'(pending), 16'h0000);
        checkOutput("flush_issue_err", 16'(err),      16'h0000);

        // Underflow: retire with nothing in flight.
        runCycle(1'b0, 1'b1, 16'h0005, 1'b0);
        checkOutput("udf_nzp_p",    16'(nzp),         16'h0001);
        checkOutput("udf_pending",  16'(pending),     16'h0000);
        checkOutput("udf_err",      16'(err),         16'h0001);
        for (int i = 0; i < 3; i++) begin
            stepClock();
        end
        checkOutput("udf_err_sticky", 16'(err),       16'h0001);
        rst = 1'b1;
        #1;
        checkOutput("udf_err_rst",  16'(err),         16'h0000);
        stepClock();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
